// File: rtl/balance_pkg.sv
// balance_pkg: shared state encoding, limits and saturating helpers for the balance controller
package balance_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        RAMP  = 2'd1,
        RUN   = 2'd2,
        COAST = 2'd3
    } bal_state_t;

    localparam int SAT_MAX  = 2047;
    localparam int SAT_MIN  = -2048;
    localparam int PSAT_MAX = 511;
    localparam int PSAT_MIN = -512;

    localparam logic [11:0] STEER_LO  = 12'h200;
    localparam logic [11:0] STEER_HI  = 12'hE00;
    localparam logic [11:0] STEER_CTR = 12'h7FF;

    function automatic logic signed [11:0] sat12(input logic signed [17:0] v);
        return (v > 18'(SAT_MAX)) ? 12'(SAT_MAX) : (v < 18'(SAT_MIN)) ? 12'(SAT_MIN) : v[11:0];
    endfunction

    // Move cur toward tgt by at most lim; never overshoots so the result stays in 12 bits
    function automatic logic signed [11:0] slew_to(input logic signed [11:0] cur,
                                                  input logic signed [11:0] tgt,
                                                  input int lim);
        logic signed [12:0] d;
        logic signed [12:0] l;
        d = 13'(tgt) - 13'(cur);
        l = 13'(lim);
        return 12'(13'(cur) + ((d > l) ? l : (d < -l) ? -l : d));
    endfunction

    function automatic logic [12:0] mag(input logic signed [11:0] v);
        return v[11] ? -13'(v) : 13'(v);
    endfunction

endpackage

// File: rtl/pid_core.sv
// pid_core: stage-1 P/I/D terms with an overflow-holding integrator
module pid_core
    import balance_pkg::*;
#(
    parameter int PW       = 16,
    parameter int FAST_SIM = 1,
    parameter int P_COEF   = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 acc,
    input  logic signed [PW-1:0] ptch,
    input  logic signed [PW-1:0] ptch_rt,
    output logic signed [14:0]   p_q,
    output logic signed [14:0]   i_q,
    output logic signed [14:0]   d_q,
    output logic                 vld_q
);

    localparam int ISH = FAST_SIM ? 6 : 12;

    logic signed [9:0]  ps;
    logic signed [17:0] integ;
    logic signed [17:0] sum;
    logic signed [17:0] nxt;
    logic               ovf;

    // Saturate pitch and form the next integrator value; a sign flip against both operands holds
    always_comb begin
        ps  = (ptch > PW'(PSAT_MAX)) ? 10'(PSAT_MAX) : (ptch < PW'(PSAT_MIN)) ? 10'(PSAT_MIN) : ptch[9:0];
        sum = integ + 18'(ps);
        ovf = (integ[17] == ps[9]) && (sum[17] != integ[17]);
        nxt = clr ? '0 : (en && acc && !ovf) ? sum : integ;
    end

    // Integrator state
    always_ff @(posedge clk) begin
        if (rst)
            integ <= '0;
        else
            integ <= nxt;
    end

    // Stage-1 register; I is taken from the freshly updated integrator
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q   <= '0;
            i_q   <= '0;
            d_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= en;
            if (en) begin
                p_q <= 15'(ps * 15'(P_COEF));
                i_q <= 15'(nxt >>> ISH);
                d_q <= 15'(ptch_rt >>> 6);
            end
        end
    end

endmodule

// File: rtl/balance_cntrl_gen.sv
// balance_cntrl_gen: ride state machine, soft-start, steering, slew and overspeed around pid_core
module balance_cntrl_gen
    import balance_pkg::*;
#(
    parameter int PW       = 16,
    parameter int FAST_SIM = 1,
    parameter int P_COEF   = 9,
    parameter int SLEW     = 64,
    parameter int FAST_HI  = 1536,
    parameter int FAST_LO  = 1280
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vld,
    input  logic signed [PW-1:0] ptch,
    input  logic signed [PW-1:0] ptch_rt,
    input  logic                 pwr_up,
    input  logic                 rider_off,
    input  logic [11:0]          steer_pot,
    input  logic                 en_steer,
    output logic signed [11:0]   lft_spd,
    output logic signed [11:0]   rght_spd,
    output logic                 too_fast,
    output logic [1:0]           state
);

    localparam int F   = FAST_SIM ? 1 : 15;
    localparam int SCW = 8 + F;

    bal_state_t         cur, nxt;
    logic [SCW-1:0]     ss_cnt;
    logic [7:0]         ss_tmr;
    logic               en, acc, clr_off, clr_int;
    logic signed [14:0] p_q, i_q, d_q;
    logic               vld_q;
    logic [11:0]        sp;
    logic signed [12:0] sc;
    logic signed [10:0] steer_d, steer_q;
    logic signed [16:0] pid17;
    logic signed [11:0] pid, scaled, tl, tr;
    logic               hi, lo;

    assign state  = cur;
    assign ss_tmr = ss_cnt[SCW-1 -: 8];

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            cur <= OFF;
        else
            cur <= nxt;
    end

    // Next state; loss of power wins over everything
    always_comb begin
        nxt = !pwr_up ? OFF :
              (cur == OFF) ? (rider_off ? OFF : RAMP) :
              (cur != COAST && rider_off) ? COAST :
              (cur == RAMP && &ss_cnt) ? RUN :
              (cur == COAST && !rider_off && ~|lft_spd && ~|rght_spd) ? RAMP : cur;
    end

    // State-derived controls for sample acceptance and clearing
    always_comb begin
        en      = vld && pwr_up && cur != OFF;
        acc     = cur == RAMP || cur == RUN;
        clr_off = !pwr_up || cur == OFF;
        clr_int = clr_off || cur == COAST;
    end

    // Soft-start counter: counts per clock in RAMP, holds in RUN, clears elsewhere
    always_ff @(posedge clk) begin
        if (rst || clr_off)
            ss_cnt <= '0;
        else
            ss_cnt <= (cur == RAMP) ? ss_cnt + SCW'(!(&ss_cnt)) : (cur == RUN) ? ss_cnt : '0;
    end

    // Steering offset from the clipped, centred pot reading
    always_comb begin
        sp      = (steer_pot < STEER_LO) ? STEER_LO : (steer_pot > STEER_HI) ? STEER_HI : steer_pot;
        sc      = $signed({1'b0, sp}) - $signed({1'b0, STEER_CTR});
        steer_d = en_steer ? 11'((15'(sc) * 15'sd3) >>> 4) : '0;
    end

    // Stage-1 steer register alongside the PID terms
    always_ff @(posedge clk) begin
        if (rst)
            steer_q <= '0;
        else if (en)
            steer_q <= steer_d;
    end

    pid_core #(
        .PW      (PW),
        .FAST_SIM(FAST_SIM),
        .P_COEF  (P_COEF)
    ) u_pid (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_int),
        .en     (en),
        .acc    (acc),
        .ptch   (ptch),
        .ptch_rt(ptch_rt),
        .p_q    (p_q),
        .i_q    (i_q),
        .d_q    (d_q),
        .vld_q  (vld_q)
    );

    // Stage-2 targets; the state seen here decides scaling and coast, so in-flight samples follow it
    always_comb begin
        pid17  = 17'(p_q) + 17'(i_q) - 17'(d_q);
        pid    = sat12(18'(pid17));
        scaled = (cur == RAMP) ? 12'((21'(pid) * $signed({13'b0, ss_tmr})) >>> 8) : pid;
        tl     = (cur == COAST) ? '0 : sat12(18'(scaled) + 18'(steer_q));
        tr     = (cur == COAST) ? '0 : sat12(18'(scaled) - 18'(steer_q));
        hi     = mag(tl) >= 13'(FAST_HI) || mag(tr) >= 13'(FAST_HI);
        lo     = mag(tl) < 13'(FAST_LO) && mag(tr) < 13'(FAST_LO);
    end

    // Stage-2 register: slewed wheel speeds and hysteretic overspeed flag
    always_ff @(posedge clk) begin
        if (rst || clr_off) begin
            lft_spd  <= '0;
            rght_spd <= '0;
            too_fast <= 1'b0;
        end else if (vld_q) begin
            lft_spd  <= slew_to(lft_spd, tl, SLEW);
            rght_spd <= slew_to(rght_spd, tr, SLEW);
            too_fast <= hi ? 1'b1 : lo ? 1'b0 : too_fast;
        end
    end

endmodule
